// File: rtl/dcache_responder.sv
// -----------------------------------------------------------------------------
// dcache_responder
//
// Data-port responder for the 8-bit RISC-V core. It puts a direct-mapped,
// write-through, no-write-allocate cache in front of a slow backing memory
// that uses a req/ack handshake.
//   - Read hits are served combinationally with no stall.
//   - Read misses fetch the word from memory and fill the line.
//   - All writes go to memory. The line is updated only on a hit.
// The core holds MemRead/MemWrite while busy=1. The one-cycle DONE state
// releases it.
//
// Ports
//   clock      : rising-edge clock
//   reset      : asynchronous, active-low reset
//   addr       : byte address from the datapath
//   wdata      : store data
//   MemRead    : load request (level)
//   MemWrite   : store request (level, has priority over MemRead)
//   rdata      : load data, valid when MemRead=1 and busy=0
//   busy       : stall towards the controller
//   mem_req    : backing-memory request, held until mem_ack
//   mem_we     : backing-memory write enable
//   mem_addr   : backing-memory address
//   mem_wdata  : backing-memory write data
//   mem_rdata  : backing-memory read data, valid with mem_ack
//   mem_ack    : single-cycle completion pulse
// -----------------------------------------------------------------------------
module dcache_responder #(
    parameter int NBITS  = 8,
    parameter int NLINES = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [NBITS-1:0] addr,
    input  logic [NBITS-1:0] wdata,
    input  logic             MemRead,
    input  logic             MemWrite,
    output logic [NBITS-1:0] rdata,
    output logic             busy,
    output logic             mem_req,
    output logic             mem_we,
    output logic [NBITS-1:0] mem_addr,
    output logic [NBITS-1:0] mem_wdata,
    input  logic [NBITS-1:0] mem_rdata,
    input  logic             mem_ack
);

    localparam int IDX_W = $clog2(NLINES);
    localparam int TAG_W = NBITS - IDX_W;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        WRITE,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [NLINES-1:0] valid_q;
    logic [TAG_W-1:0]  tag_q  [NLINES];
    logic [NBITS-1:0]  data_q [NLINES];
    logic [NBITS-1:0]  hold_q;

    logic [IDX_W-1:0]  index;
    logic [TAG_W-1:0]  tag;
    logic              hit;
    logic              fill_en;   // read miss completing: allocate the line
    logic              upd_en;    // write hit completing: refresh the line data

    assign index = addr[IDX_W-1:0];
    assign tag   = addr[NBITS-1:IDX_W];
    assign hit   = valid_q[index] && (tag_q[index] == tag);

    // Next state and outputs.
    always_comb begin
        // NOTE: every signal gets a default before the case, so no path leaves one unassigned and no latch is inferred.
        state_d   = state_q;
        busy      = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        rdata     = '0;
        fill_en   = 1'b0;
        upd_en    = 1'b0;

        case (state_q)
            IDLE: begin
                if (MemWrite) begin
                    busy    = 1'b1;
                    state_d = WRITE;
                end else if (MemRead) begin
                    if (hit) begin
                        rdata = data_q[index];
                    end else begin
                        busy    = 1'b1;
                        state_d = FETCH;
                    end
                end
            end

            // The transaction runs to DONE even if the core drops its request.
            FETCH: begin
                busy     = 1'b1;
                mem_req  = 1'b1;
                mem_addr = addr;
                if (mem_ack) begin
                    fill_en = 1'b1;
                    state_d = DONE;
                end
            end

            WRITE: begin
                busy      = 1'b1;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = addr;
                mem_wdata = wdata;
                if (mem_ack) begin
                    upd_en  = hit;     // no-write-allocate: a miss leaves the line alone
                    state_d = DONE;
                end
            end

            // The core advances this cycle. Requests seen here are ignored.
            DONE: begin
                rdata   = hold_q;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    // Control state, valid bits and holding register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            valid_q <= '0;
            hold_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            if (fill_en) begin
                valid_q[index] <= 1'b1;
                hold_q         <= mem_rdata;
            end
        end
    end

    // NOTE: tag/data arrays carry no reset; a line is only trusted once its valid bit is set.
    always_ff @(posedge clock) begin
        if (fill_en) begin
            tag_q[index]  <= tag;
            data_q[index] <= mem_rdata;
        end else if (upd_en) begin
            data_q[index] <= wdata;
        end
    end

endmodule
